telemetry_frame_receiver: RTL and testbench
===========================================

Name: telemetry_frame_receiver

Overview:
- Host-side receiver for the telemetry byte stream that the converter core emits as (data, valid) pairs.
- Hunts for a frame sync byte and reads the length byte and payload.
- Verifies an XOR checksum, then commits good payload bytes into a small FIFO for readout. Bad frames are rolled back and never become visible.
- Keeps saturating good/bad frame counters for link-health monitoring.

Parameters:
- FIFO_DEPTH, 16, payload FIFO entries; power of two, 4..256
- MAX_PAYLOAD, 8, largest legal LEN value; must be <= FIFO_DEPTH
- TIMEOUT_CYCLES, 64, idle cycles allowed between bytes inside a frame before abort
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  incoming stream byte
- in_valid  in  1  in_data is valid this cycle; no backpressure
- rd_en  in  1  pop one committed byte; ignored when empty
- rd_data  out  8  popped byte, registered
- rd_valid  out  1  rd_data valid, one-cycle pulse
- empty  out  1  no committed bytes available
- level  out  $clog2(FIFO_DEPTH)+1  committed byte count
- frame_ok  out  1  one-cycle pulse on good checksum
- frame_err  out  1  one-cycle pulse on any frame abort
- ok_count  out  16  good frames, saturates at 16'hFFFF
- err_count  out  16  aborted frames, saturates at 16'hFFFF
- busy  out  1  FSM not in HUNT

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Reset clears pointers, counters, checksum and timer; FSM goes to HUNT.
  - After reset: all outputs 0 except empty=1.
  - Reset mid-frame discards all uncommitted bytes without pulsing frame_err. Reset also clears already-committed bytes.
- FIFO pointers:
  - wr_ptr is speculative; commit_ptr and rd_ptr are architectural.
  - level and empty derive from commit_ptr-rd_ptr only.
- FSM:
  - HUNT: on a valid byte == SYNC_BYTE go to LEN. Other bytes are dropped silently (no error).
  - LEN:
    - If the valid byte is 0 or > MAX_PAYLOAD: pulse frame_err, err_count++, go to HUNT.
    - Else if (FIFO_DEPTH - (wr_ptr-rd_ptr)) < LEN: go to DROP.
    - Else go to PAYLOAD.
    - In both DROP and PAYLOAD cases: remaining=LEN, csum=LEN.
  - PAYLOAD: each valid byte is written at wr_ptr, wr_ptr++, csum^=byte, remaining--. When remaining reaches 0, go to CHK.
  - DROP: consume LEN payload bytes without writing, then consume one checksum byte. Then pulse frame_err, err_count++, go to HUNT (overflow counts as error).
  - CHK:
    - Valid byte == csum: commit_ptr<=wr_ptr, pulse frame_ok, ok_count++.
    - Mismatch: wr_ptr<=commit_ptr, pulse frame_err, err_count++.
    - Either way go to HUNT.
- SYNC_BYTE inside LEN/PAYLOAD/CHK is treated as data, with no resync.
- Timeout:
  - Timer runs in every state except HUNT and reloads on each valid byte.
  - When TIMEOUT_CYCLES consecutive cycles pass without in_valid: roll back wr_ptr, pulse frame_err, err_count++, go to HUNT.
- Latency:
  - frame_ok/frame_err pulse the cycle after the checksum (or terminating) byte.
  - Committed bytes count toward level/empty in that same cycle.
- Reads:
  - rd_en with !empty: rd_data/rd_valid appear the next cycle, rd_ptr++.
  - rd_en while empty: no effect, rd_valid=0.
  - A read and a commit in the same cycle are both honoured.
  - Free space is computed against rd_ptr, so a concurrent read never corrupts an in-flight frame.
- Pointers wrap modulo FIFO_DEPTH with one extra bit for full/empty.
- Counters hold at 16'hFFFF.

Test Plan:
1. Good frame: bytes A5,03,10,20,30,checksum 03^10^20^30=03 -> frame_ok pulse, level=3, ok_count=1. Then 3 reads -> rd_data 10,20,30, empty=1.
2. Bad checksum: A5,02,11,22,checksum FF (expected 31) -> frame_err pulse, err_count=1, level stays 0, following good frame reads back intact.
3. Illegal length: A5,00 and A5,09 (MAX_PAYLOAD=8) -> two frame_err pulses, err_count=2, FSM back in HUNT.
4. Overflow: with level=12 (FIFO_DEPTH=16), send A5,08, 8 bytes, checksum -> DROP path, frame_err, level remains 12. Read 4 bytes, resend -> accepted, level=16.
5. Timeout: A5,04,01 then 64 idle cycles -> frame_err on timeout, wr_ptr rolled back, busy=0. Leading junk bytes 00,FF before a good frame produce no error.
6. Concurrent read/commit plus reset: read each cycle while frames commit across the pointer wrap -> data order preserved. Assert rst mid-PAYLOAD -> empty=1, counters 0, no frame_err pulse.

Source files
------------

// File: rtl/telemetry_frame_receiver.sv
// Telemetry frame receiver: sync hunt, length/payload parse, XOR checksum, commit-or-rollback FIFO.
// Events/readout are registered (one cycle); input has no backpressure, frames that do not fit are dropped.
module telemetry_frame_receiver #(
    parameter int          FIFO_DEPTH     = 16,
    parameter int          MAX_PAYLOAD    = 8,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    input  logic                            rd_en,
    output logic [7:0]                      rd_data,
    output logic                            rd_valid,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            frame_ok,
    output logic                            frame_err,
    output logic [15:0]                     ok_count,
    output logic [15:0]                     err_count,
    output logic                            busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [7:0]    MAXP    = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, DROP, CHK} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0]   free_space;
    logic [7:0]      csum, remaining;
    logic [TW-1:0]   idle_cnt;

    logic timeout, len_bad, no_room;
    logic load_len, do_write, dec_drop, do_commit, do_rollback, ev_ok, ev_err;

    // Free space is measured from rd_ptr so in-flight (uncommitted) bytes are reserved too.
    assign free_space = DEPTH_P - (wr_ptr - rd_ptr);
    assign no_room    = 16'(free_space) < 16'(in_data);
    assign len_bad    = (in_data == 8'd0) || (in_data > MAXP);
    assign timeout    = (state != HUNT) && !in_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign level = commit_ptr - rd_ptr;
    assign empty = (level == '0);
    assign busy  = (state != HUNT);

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: if (in_valid && in_data == SYNC_BYTE) state_nxt = LEN;
            LEN: begin
                if (timeout)                    state_nxt = HUNT;
                else if (in_valid) begin
                    if (len_bad)                state_nxt = HUNT;
                    else if (no_room)           state_nxt = DROP;
                    else                        state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (timeout)                                state_nxt = HUNT;
                else if (in_valid && remaining == 8'd1)     state_nxt = CHK;
            end
            DROP: begin
                if (timeout)                                state_nxt = HUNT;
                else if (in_valid && remaining == 8'd0)     state_nxt = HUNT;
            end
            CHK: if (timeout || in_valid) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        load_len    = 1'b0;
        do_write    = 1'b0;
        dec_drop    = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        ev_ok       = 1'b0;
        ev_err      = 1'b0;
        if (timeout) begin
            do_rollback = 1'b1;
            ev_err      = 1'b1;
        end else if (in_valid) begin
            case (state)
                LEN: begin
                    if (len_bad) ev_err   = 1'b1;
                    else         load_len = 1'b1;
                end
                PAYLOAD: do_write = 1'b1;
                DROP: begin
                    if (remaining == 8'd0) ev_err   = 1'b1;
                    else                   dec_drop = 1'b1;
                end
                CHK: begin
                    if (in_data == csum) begin
                        do_commit = 1'b1;
                        ev_ok     = 1'b1;
                    end else begin
                        do_rollback = 1'b1;
                        ev_err      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            csum       <= '0;
            remaining  <= '0;
            idle_cnt   <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            ok_count   <= '0;
            err_count  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            frame_ok  <= ev_ok;
            frame_err <= ev_err;
            if (ev_ok && ok_count != 16'hFFFF)   ok_count  <= ok_count + 16'd1;
            if (ev_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;

            if (load_len) begin
                remaining <= in_data;
                csum      <= in_data;
            end else if (do_write) begin
                remaining <= remaining - 8'd1;
                csum      <= csum ^ in_data;
            end else if (dec_drop) begin
                remaining <= remaining - 8'd1;
            end

            if (do_write)         wr_ptr <= wr_ptr + PW'(1);
            else if (do_rollback) wr_ptr <= commit_ptr;
            if (do_commit)        commit_ptr <= wr_ptr;

            if (state == HUNT || in_valid) idle_cnt <= '0;
            else                           idle_cnt <= idle_cnt + TW'(1);

            rd_valid <= 1'b0;
            if (rd_en && !empty) begin
                rd_data  <= mem[rd_ptr[AW-1:0]];
                rd_valid <= 1'b1;
                rd_ptr   <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_telemetry_frame_receiver.sv
// Directed bench for telemetry_frame_receiver with queue-based scoreboard and decoupled monitor.
module tb_telemetry_frame_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic [4:0]  level;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] ok_count;
    logic [15:0] err_count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ok_exp = 0;
    int err_exp = 0;

    logic [7:0] rd_q[$];
    int         ev_q[$];
    logic [7:0] fb[$];

    telemetry_frame_receiver #(
        .FIFO_DEPTH(16), .MAX_PAYLOAD(8), .TIMEOUT_CYCLES(64), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .level(level),
        .frame_ok(frame_ok), .frame_err(frame_err), .ok_count(ok_count),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents readout data or a frame event.
    always @(negedge clk) begin
        logic [7:0] e;
        int k;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected got %0h expected none", rd_data);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", int'(rd_data), int'(e));
            end
        end
        if (frame_ok || frame_err) begin
            k = (frame_ok ? 1 : 0) + (frame_err ? 2 : 0);
            if (ev_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL event_unexpected got %0d expected none", k);
            end else begin
                chk("frame_event", k, ev_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
    endtask

    // kind: 0 no event, 1 good frame (payload expected on readout), 2 error event
    task automatic send_fb(input int kind, input int npay);
        if (kind == 1) begin
            for (int i = 0; i < npay; i++) rd_q.push_back(fb[2 + i]);
            ev_q.push_back(1);
            ok_exp++;
        end else if (kind == 2) begin
            ev_q.push_back(2);
            err_exp++;
        end
        foreach (fb[i]) send_byte(fb[i]);
    endtask

    task automatic make_good(input int len, input logic [7:0] base);
        logic [7:0] c;
        c = 8'(len);
        fb = {8'hA5, 8'(len)};
        for (int i = 0; i < len; i++) begin
            fb.push_back(base + 8'(i));
            c = c ^ (base + 8'(i));
        end
        fb.push_back(c);
    endtask

    task automatic do_reads(input int n);
        repeat (n) begin
            rd_en = 1'b1;
            cyc(1);
        end
        rd_en = 1'b0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_ok_count"}, int'(ok_count), ok_exp);
        chk({tag, "_err_count"}, int'(err_count), err_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; rd_en = 1'b0;
        cyc(3);
        rst = 1'b0;
        chk("reset_empty", int'(empty), 1);
        chk("reset_level", int'(level), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk_counts("reset");

        // 1: good frame, checksum 03^10^20^30 = 03
        fb = {8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
        send_fb(1, 3);
        cyc(2);
        chk("t1_level", int'(level), 3);
        chk_counts("t1");
        do_reads(3);
        cyc(2);
        chk("t1_empty", int'(empty), 1);

        // 2: bad checksum (expected 31), then the same frame with the right checksum
        fb = {8'hA5, 8'h02, 8'h11, 8'h22, 8'hFF};
        send_fb(2, 0);
        cyc(2);
        chk("t2_level", int'(level), 0);
        chk_counts("t2");
        fb = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
        send_fb(1, 2);
        cyc(1);
        do_reads(2);
        cyc(2);

        // 3: illegal lengths
        fb = {8'hA5, 8'h00};
        send_fb(2, 0);
        fb = {8'hA5, 8'h09};
        send_fb(2, 0);
        cyc(2);
        chk_counts("t3");
        chk("t3_busy", int'(busy), 0);

        // 4: overflow drop with level 12, then accept after reading 4
        make_good(8, 8'h40); send_fb(1, 8);
        make_good(4, 8'h50); send_fb(1, 4);
        cyc(2);
        chk("t4_level12", int'(level), 12);
        make_good(8, 8'h60); send_fb(2, 0);
        cyc(2);
        chk("t4_level_after_drop", int'(level), 12);
        chk_counts("t4_drop");
        do_reads(4);
        make_good(8, 8'h60); send_fb(1, 8);
        cyc(2);
        chk("t4_level16", int'(level), 16);
        do_reads(16);
        cyc(2);
        chk("t4_drained", int'(empty), 1);

        // 5: timeout after 64 idle cycles, rollback, then junk before a good frame
        fb = {8'hA5, 8'h04, 8'h01};
        send_fb(2, 0);
        cyc(62);
        chk("t5_busy_before_timeout", int'(busy), 1);
        cyc(2);
        chk("t5_busy_after_timeout", int'(busy), 0);
        chk("t5_level", int'(level), 0);
        chk_counts("t5");
        fb = {8'h00, 8'hFF};
        send_fb(0, 0);
        fb = {8'hA5, 8'h01, 8'h77, 8'h76};
        send_fb(1, 1);
        cyc(1);
        do_reads(1);
        cyc(2);

        // 6: continuous reads while frames commit across the pointer wrap
        fork
            do_reads(70);
            begin
                for (int f = 0; f < 4; f++) begin
                    make_good(6, 8'h80 + 8'(f * 8));
                    send_fb(1, 6);
                end
            end
        join
        cyc(3);
        chk("t6_empty", int'(empty), 1);
        chk_counts("t6");

        // 6b: reset mid-payload clears committed and in-flight data, no error pulse
        make_good(2, 8'hAA); send_fb(1, 2);
        cyc(3);
        fb = {8'hA5, 8'h03, 8'h01};
        send_fb(0, 0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        rd_q.delete();
        ok_exp = 0;
        err_exp = 0;
        cyc(1);
        chk("t6_rst_empty", int'(empty), 1);
        chk("t6_rst_level", int'(level), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk_counts("t6_rst");
        fb = {8'hA5, 8'h01, 8'h5A, 8'h5B};
        send_fb(1, 1);
        cyc(1);
        do_reads(1);
        cyc(3);
        chk_counts("final");
        chk("final_rd_q_left", rd_q.size(), 0);
        chk("final_ev_q_left", ev_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
